rv32imf_wfi_ctrl: RTL and testbench
===================================

Name: rv32imf_wfi_ctrl

Overview:
Upstream companion of the core sleep unit. Decodes the WFI sleep protocol: accepts a WFI request from the controller, drains the pipeline, and parks the core. It then watches enabled interrupts and debug requests and raises wake_from_sleep_o early enough that the sleep unit re-enables the gated clock. Runs on the ungated clock and drives the sleep unit's ctrl_busy and wake inputs.

Parameters:
IRQ_WIDTH, 32, width of the pending and enable interrupt vectors (mip/mie view)
WAKE_HOLD, 2, cycles spent in the WAKE state before returning to RUN (1..15)
CNT_WIDTH, 32, width of the sleep-cycle counter

Ports:
clk_ungated_i  in  1  free-running core clock, never gated
rst  in  1  asynchronous, active-high reset
wfi_req_i  in  1  WFI present in ID; level, held until wfi_ack_o
wfi_ack_o  out  1  one-cycle pulse: WFI may retire
if_busy_i  in  1  fetch stage busy
lsu_busy_i  in  1  LSU has outstanding transactions
apu_busy_i  in  1  FPU/APU busy
irq_pending_i  in  IRQ_WIDTH  pending interrupt lines
irq_enable_i  in  IRQ_WIDTH  per-line enables
debug_req_i  in  1  external debug request
debug_mode_i  in  1  core currently in debug mode
wake_from_sleep_o  out  1  to the sleep unit; forces the clock enable
ctrl_busy_o  out  1  to the sleep unit ctrl_busy input
sleeping_o  out  1  core parked (status/CSR)
wake_cause_o  out  2  0 none, 1 irq, 2 debug
sleep_cycles_o  out  CNT_WIDTH  cycles spent in SLEEP during the last episode

Behaviour:
- Reset state: RUN. Reset values: wfi_ack_o=0, wake_from_sleep_o=0, ctrl_busy_o=1, sleeping_o=0, wake_cause_o=0, sleep_cycles_o=0.
- wake_cond = |(irq_pending_i & irq_enable_i) | debug_req_i. Evaluation is independent of the global MIE bit.
- The cause is always debug when debug_req_i is high, otherwise irq.
- RUN: ctrl_busy_o=1.
  - wfi_req_i with debug_mode_i=1 or wake_cond=1: the WFI acts as a NOP. wfi_ack_o pulses combinationally in the same cycle. State stays RUN. wake_cause_o is not updated.
  - wfi_req_i otherwise: go to DRAIN. sleep_cycles_o clears to 0 and wake_cause_o clears to 0.
- DRAIN: ctrl_busy_o=1.
  - wake_cond: go to WAKE and register the cause. This check has priority over the drain check.
  - Else, when if_busy_i, lsu_busy_i and apu_busy_i are all 0: go to SLEEP.
- SLEEP: ctrl_busy_o=0, sleeping_o=1.
  - sleep_cycles_o increments by 1 each cycle and saturates at all-ones (no wrap).
  - wake_cond: wake_from_sleep_o goes high combinationally in the same cycle. Next state is WAKE and the cause is registered.
- WAKE: ctrl_busy_o=1, wake_from_sleep_o=1, sleeping_o=0.
  - A hold counter runs WAKE_HOLD cycles, then state returns to RUN.
  - wfi_ack_o pulses on the final WAKE cycle.
  - wake_cause_o and sleep_cycles_o hold until the next WFI entry.
- Latency, SLEEP to RUN: wake_from_sleep_o is high in the detect cycle plus WAKE_HOLD cycles. The ack arrives WAKE_HOLD cycles after detection.
- wfi_req_i is ignored outside RUN. wfi_ack_o never pulses twice for one request.
- Wake events that are not WFI-related (wake_cond while in RUN) have no effect.
- A wake_cond pulse only one cycle wide in SLEEP is sufficient: it is latched by the state transition.
- Debug and irq arriving in the same cycle: cause=2.
- Reset asserted mid-operation, in any state, returns immediately and asynchronously to RUN with reset values. No ack is generated for the aborted WFI.

Decomposition:
- rv32imf_pkg gains:
  - wfi_state_e {WFI_RUN, WFI_DRAIN, WFI_SLEEP, WFI_WAKE}
  - wake_cause_e {WAKE_NONE=0, WAKE_IRQ=1, WAKE_DBG=2}
- No sub-module. The saturating counter and hold counter are inline.

Test Plan:
- Reset, then idle: ctrl_busy_o=1, wake_from_sleep_o=0, state RUN.
- WFI with all busy signals 0 and no irq: DRAIN for 1 cycle, then SLEEP.
  - Raise irq_pending_i[3] with irq_enable_i[3]=1 after 10 SLEEP cycles: wake_from_sleep_o high for 3 cycles (WAKE_HOLD=2).
  - Expect wfi_ack_o pulse 2 cycles after detection, wake_cause_o=1, sleep_cycles_o=10.
- WFI with irq_pending_i[7]=1 and irq_enable_i[7]=1 already: wfi_ack_o in the same cycle, no DRAIN, sleep_cycles_o unchanged.
- WFI with lsu_busy_i held high 5 cycles: stays in DRAIN 5 cycles with ctrl_busy_o=1, then SLEEP.
- WFI with debug_mode_i=1: NOP ack.
  - Separately, irq and debug_req_i asserted in the same SLEEP cycle: wake_cause_o=2.
- Assert rst during SLEEP: sleeping_o=0, ctrl_busy_o=1 immediately, and no wfi_ack_o afterwards.
- Force saturation with CNT_WIDTH=4: 20 SLEEP cycles give sleep_cycles_o=15.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared types for the rv32imf core slice: WFI sleep-protocol state and wake cause.
package rv32imf_pkg;

    typedef enum logic [1:0] {
        WFI_RUN,
        WFI_DRAIN,
        WFI_SLEEP,
        WFI_WAKE
    } wfi_state_e;

    typedef enum logic [1:0] {
        WAKE_NONE = 2'd0,
        WAKE_IRQ  = 2'd1,
        WAKE_DBG  = 2'd2
    } wake_cause_e;

endpackage

// File: rtl/rv32imf_wfi_ctrl.sv
// WFI controller: drains the pipeline on WFI, parks the core, and raises the
// wake request to the sleep unit on an enabled interrupt or debug request.
module rv32imf_wfi_ctrl
    import rv32imf_pkg::*;
#(
    parameter int IRQ_WIDTH = 32,
    parameter int WAKE_HOLD = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_ungated_i,
    input  logic                 rst,
    input  logic                 wfi_req_i,
    output logic                 wfi_ack_o,
    input  logic                 if_busy_i,
    input  logic                 lsu_busy_i,
    input  logic                 apu_busy_i,
    input  logic [IRQ_WIDTH-1:0] irq_pending_i,
    input  logic [IRQ_WIDTH-1:0] irq_enable_i,
    input  logic                 debug_req_i,
    input  logic                 debug_mode_i,
    output logic                 wake_from_sleep_o,
    output logic                 ctrl_busy_o,
    output logic                 sleeping_o,
    output logic [1:0]           wake_cause_o,
    output logic [CNT_WIDTH-1:0] sleep_cycles_o
);

    localparam logic [3:0] HOLD_LAST = 4'(WAKE_HOLD - 1);

    wfi_state_e           state_q, state_d;
    wake_cause_e          cause_q, cause_d;
    logic [3:0]           hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic        wake_cond;
    logic        wfi_nop;
    wake_cause_e cause_now;

    // Global MIE is deliberately ignored: any enabled pending line wakes the core.
    assign wake_cond = (|(irq_pending_i & irq_enable_i)) | debug_req_i;
    assign cause_now = debug_req_i ? WAKE_DBG : WAKE_IRQ;
    assign wfi_nop   = wfi_req_i & (debug_mode_i | wake_cond);

    always_ff @(posedge clk_ungated_i or posedge rst) begin
        if (rst) begin
            state_q <= WFI_RUN;
            cause_q <= WAKE_NONE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WFI_RUN: begin
                if (wfi_req_i && !wfi_nop) begin
                    state_d = WFI_DRAIN;
                    cause_d = WAKE_NONE;
                    cnt_d   = '0;
                end
            end
            WFI_DRAIN: begin
                if (wake_cond) begin
                    state_d = WFI_WAKE;
                    cause_d = cause_now;
                    hold_d  = '0;
                end else if (!(if_busy_i | lsu_busy_i | apu_busy_i)) begin
                    state_d = WFI_SLEEP;
                end
            end
            WFI_SLEEP: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (wake_cond) begin
                    state_d = WFI_WAKE;
                    cause_d = cause_now;
                    hold_d  = '0;
                end
            end
            WFI_WAKE: begin
                if (hold_q == HOLD_LAST) state_d = WFI_RUN;
                else                     hold_d  = hold_q + 4'd1;
            end
            default: state_d = WFI_RUN;
        endcase
    end

    always_comb begin
        wfi_ack_o         = 1'b0;
        wake_from_sleep_o = 1'b0;
        ctrl_busy_o       = 1'b1;
        sleeping_o        = 1'b0;
        unique case (state_q)
            WFI_RUN:   wfi_ack_o = wfi_nop & ~rst;
            WFI_DRAIN: ;
            WFI_SLEEP: begin
                ctrl_busy_o       = 1'b0;
                sleeping_o        = 1'b1;
                wake_from_sleep_o = wake_cond;
            end
            WFI_WAKE: begin
                wake_from_sleep_o = 1'b1;
                wfi_ack_o         = (hold_q == HOLD_LAST) & ~rst;
            end
            default: ;
        endcase
    end

    assign wake_cause_o   = cause_q;
    assign sleep_cycles_o = cnt_q;

endmodule

// File: tb/tb_rv32imf_wfi_ctrl.sv
// Bench for rv32imf_wfi_ctrl: table vectors, directed corner sequences and
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_rv32imf_wfi_ctrl;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wfi_req, if_busy, lsu_busy, apu_busy, debug_req, debug_mode;
    logic [31:0] irq_pend, irq_en;

    logic        ack1, wake1, busy1, slp1;
    logic [1:0]  cause1;
    logic [31:0] cnt1;
    logic        ack2, wake2, busy2, slp2;
    logic [1:0]  cause2;
    logic [3:0]  cnt2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32imf_wfi_ctrl #(.IRQ_WIDTH(32), .WAKE_HOLD(HOLD), .CNT_WIDTH(32)) dut (
        .clk_ungated_i(clk), .rst(rst), .wfi_req_i(wfi_req), .wfi_ack_o(ack1),
        .if_busy_i(if_busy), .lsu_busy_i(lsu_busy), .apu_busy_i(apu_busy),
        .irq_pending_i(irq_pend), .irq_enable_i(irq_en),
        .debug_req_i(debug_req), .debug_mode_i(debug_mode),
        .wake_from_sleep_o(wake1), .ctrl_busy_o(busy1), .sleeping_o(slp1),
        .wake_cause_o(cause1), .sleep_cycles_o(cnt1));

    rv32imf_wfi_ctrl #(.IRQ_WIDTH(32), .WAKE_HOLD(HOLD), .CNT_WIDTH(4)) dut_sat (
        .clk_ungated_i(clk), .rst(rst), .wfi_req_i(wfi_req), .wfi_ack_o(ack2),
        .if_busy_i(if_busy), .lsu_busy_i(lsu_busy), .apu_busy_i(apu_busy),
        .irq_pending_i(irq_pend), .irq_enable_i(irq_en),
        .debug_req_i(debug_req), .debug_mode_i(debug_mode),
        .wake_from_sleep_o(wake2), .ctrl_busy_o(busy2), .sleeping_o(slp2),
        .wake_cause_o(cause2), .sleep_cycles_o(cnt2));

    // Behavioural model: which phase of a WFI episode the core is in, how many
    // WAKE cycles are left, cycles slept (unbounded 64-bit) and the last cause.
    localparam int P_RUN = 0, P_DRAIN = 1, P_SLEEP = 2, P_WAKE = 3;
    int          m_phase;
    int          m_left;
    longint      m_slept;
    int          m_cause;

    function automatic logic m_wake();
        return ((irq_pend & irq_en) != 0) || debug_req;
    endfunction

    function automatic logic m_ack();
        return (m_phase == P_RUN && wfi_req && (debug_mode || m_wake())) ||
               (m_phase == P_WAKE && m_left == 1);
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic m_reset();
        m_phase = P_RUN; m_left = 0; m_slept = 0; m_cause = 0;
    endtask

    task automatic m_advance();
        logic w;
        w = m_wake();
        case (m_phase)
            P_RUN: if (wfi_req && !(debug_mode || w)) begin
                m_phase = P_DRAIN; m_slept = 0; m_cause = 0;
            end
            P_DRAIN: if (w) begin
                m_phase = P_WAKE; m_left = HOLD; m_cause = debug_req ? 2 : 1;
            end else if (!(if_busy || lsu_busy || apu_busy)) m_phase = P_SLEEP;
            P_SLEEP: begin
                m_slept++;
                if (w) begin
                    m_phase = P_WAKE; m_left = HOLD; m_cause = debug_req ? 2 : 1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = P_RUN;
            end
        endcase
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("ack",      ack1, m_ack());
        chk("wake",     wake1, (m_phase == P_SLEEP && m_wake()) || m_phase == P_WAKE);
        chk("busy",     busy1, m_phase != P_SLEEP);
        chk("sleeping", slp1, m_phase == P_SLEEP);
        chk("cause",    cause1, m_cause);
        chk("cycles",   cnt1, sat(m_slept, 64'hFFFF_FFFF));
        chk("cycles4",  cnt2, sat(m_slept, 15));
        chk("ack4",     ack2, m_ack());
    endtask

    // One clock: compare at the falling edge, advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        chk_model();
        @(posedge clk);
        m_advance();
        #1;
    endtask

    task automatic idle_inputs();
        wfi_req = 0; if_busy = 0; lsu_busy = 0; apu_busy = 0;
        debug_req = 0; debug_mode = 0; irq_pend = '0; irq_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        chk("rst_busy", busy1, 1);
        chk("rst_wake", wake1, 0);
        chk("rst_slp",  slp1, 0);
        chk("rst_ack",  ack1, 0);
        chk("rst_cnt",  cnt1, 0);
        chk("rst_cause", cause1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Enter SLEEP from RUN with nothing busy: RUN->DRAIN, DRAIN->SLEEP.
    task automatic enter_sleep();
        wfi_req = 1; step();
        wfi_req = 0; step();
    endtask

    typedef struct {
        logic wfi, lsu, irq, dmode;
        logic ack, busy, slp, wk;
    } vec_t;

    vec_t vt[16];
    int   wake_cnt, ack_at;

    initial begin
        idle_inputs();
        rst = 1'b0;
        do_reset();

        //        wfi lsu irq dm   ack busy slp wk
        vt[0]  = '{0, 0, 0, 0,  0, 1, 0, 0};
        vt[1]  = '{1, 0, 1, 0,  1, 1, 0, 0};  // pending irq: NOP ack
        vt[2]  = '{0, 0, 0, 0,  0, 1, 0, 0};
        vt[3]  = '{1, 0, 0, 1,  1, 1, 0, 0};  // debug mode: NOP ack
        vt[4]  = '{1, 1, 0, 0,  0, 1, 0, 0};  // -> DRAIN
        for (int i = 5; i <= 9; i++) vt[i] = '{1, 1, 0, 0, 0, 1, 0, 0};
        vt[10] = '{0, 0, 0, 0,  0, 1, 0, 0};  // drained -> SLEEP
        vt[11] = '{0, 0, 0, 0,  0, 0, 1, 0};
        vt[12] = '{0, 0, 1, 0,  0, 0, 1, 1};  // detect
        vt[13] = '{0, 0, 0, 0,  0, 1, 0, 1};
        vt[14] = '{0, 0, 0, 0,  1, 1, 0, 1};  // final WAKE cycle acks
        vt[15] = '{0, 0, 0, 0,  0, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            wfi_req = vt[i].wfi; lsu_busy = vt[i].lsu; debug_mode = vt[i].dmode;
            irq_pend = vt[i].irq ? 32'h80 : 32'h0;
            irq_en   = 32'h80;
            @(negedge clk);
            chk("vec_ack",  ack1,  vt[i].ack);
            chk("vec_busy", busy1, vt[i].busy);
            chk("vec_slp",  slp1,  vt[i].slp);
            chk("vec_wake", wake1, vt[i].wk);
            chk_model();
            @(posedge clk);
            m_advance();
            #1;
        end
        chk("vec_cause",  cause1, 1);
        chk("vec_cycles", cnt1, 2);
        idle_inputs();

        // Wake on irq[3] where the 10th SLEEP cycle is the detect cycle.
        irq_en = 32'h8;
        enter_sleep();
        for (int i = 0; i < 9; i++) step();
        irq_pend = 32'h8;
        wake_cnt = 0; ack_at = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wake1) wake_cnt++;
            if (ack1 && ack_at < 0) ack_at = i;
            chk_model();
            @(posedge clk);
            m_advance();
            #1;
            irq_pend = '0;
        end
        chk("irq3_wake_len", wake_cnt, 3);
        chk("irq3_ack_lat",  ack_at, 2);
        chk("irq3_cause",    cause1, 1);
        chk("irq3_cycles",   cnt1, 10);

        // NOP WFI must leave the previous episode's counters alone.
        irq_pend = 32'h80; irq_en = 32'h80; wfi_req = 1;
        @(negedge clk);
        chk("nop_ack", ack1, 1);
        chk("nop_cycles", cnt1, 10);
        @(posedge clk); m_advance(); #1;
        idle_inputs();
        step();

        // Debug and irq in the same SLEEP cycle, one cycle wide.
        irq_en = 32'h1;
        enter_sleep();
        step();
        irq_pend = 32'h1; debug_req = 1; step();
        irq_pend = '0; debug_req = 0;
        for (int i = 0; i < 3; i++) step();
        chk("dbg_cause", cause1, 2);

        // 20 SLEEP cycles: full counter reads 20, 4-bit counter saturates.
        enter_sleep();
        for (int i = 0; i < 19; i++) step();
        irq_pend = 32'h1; step();
        irq_pend = '0;
        for (int i = 0; i < 3; i++) step();
        chk("sat_cycles4",  cnt2, 15);
        chk("sat_cycles32", cnt1, 20);

        // Reset mid-SLEEP: parks nothing, no late ack.
        enter_sleep();
        step(); step();
        @(negedge clk);
        chk("pre_rst_slp", slp1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_slp",  slp1, 0);
        chk("mid_rst_busy", busy1, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_ack", ack1, 0);
        end

        // Randomized traffic; wfi drops after an ack like a retiring instruction.
        for (int i = 0; i < 600; i++) begin
            if_busy    = ($urandom_range(0, 3) == 0);
            lsu_busy   = ($urandom_range(0, 3) == 0);
            apu_busy   = ($urandom_range(0, 5) == 0);
            debug_req  = ($urandom_range(0, 40) == 0);
            debug_mode = ($urandom_range(0, 15) == 0);
            irq_en     = $urandom();
            irq_pend   = ($urandom_range(0, 12) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            if (m_phase == P_RUN && !wfi_req) wfi_req = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk_model();
            if (ack1) begin
                @(posedge clk); m_advance(); #1;
                wfi_req = 0;
            end else begin
                @(posedge clk); m_advance(); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
